// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl
//   Block-cipher mode controller wrapped around one AES core that uses a
//   START/DONE handshake. It adds ECB/CBC/CTR chaining, an input FIFO and
//   valid/ready streaming on both sides, so multi-block messages can be
//   streamed without per-block sequencing of the core.
//
//   Optional feature macro: AES_MODE_BLKCNT_EN
//     defined   : BLK_CNT counts completed output handshakes. It is cleared
//                 by reset and by an accepted IV_LOAD, and saturates at all-ones.
//     undefined : BLK_CNT is tied to 0 and no counter logic is built.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   MODE, ENCDEC, KEY    session settings (0=ECB 1=CBC 2=CTR 3=ECB), latched on IV_LOAD
//   IV, IV_LOAD          initial chain/counter value, one-cycle session start
//   BUSY                 FIFO not empty or FSM not idle
//   IN_VALID/IN_READY    input block handshake, IN_DATA block
//   OUT_VALID/OUT_READY  output block handshake, OUT_DATA block
//   CORE_START           one-cycle start pulse to the core
//   CORE_ENCDEC          core direction (forced to encrypt in CTR)
//   CORE_KEY             latched key
//   CORE_TEXTIN          core operand, held stable from START to DONE
//   CORE_DONE            core completion, honoured only while waiting
//   CORE_TEXTOUT         core result
//   BLK_CNT              completed block count (see macro above)
module aes_mode_ctrl #(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CTR_W      = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [1:0]         MODE,
  input  logic               ENCDEC,
  input  logic [BLOCK_W-1:0] KEY,
  input  logic [BLOCK_W-1:0] IV,
  input  logic               IV_LOAD,
  output logic               BUSY,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [BLOCK_W-1:0] IN_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [BLOCK_W-1:0] OUT_DATA,
  output logic               CORE_START,
  output logic               CORE_ENCDEC,
  output logic [BLOCK_W-1:0] CORE_KEY,
  output logic [BLOCK_W-1:0] CORE_TEXTIN,
  input  logic               CORE_DONE,
  input  logic [BLOCK_W-1:0] CORE_TEXTOUT,
  output logic [31:0]        BLK_CNT
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;
  typedef enum logic [1:0] {M_ECB, M_CBC, M_CTR, M_RSV} mode_t;

  state_t             r_state;
  mode_t              r_mode;
  logic               r_core_encdec;
  logic [BLOCK_W-1:0] r_key;
  logic [BLOCK_W-1:0] r_chain;
  logic [BLOCK_W-1:0] r_block;
  logic [BLOCK_W-1:0] r_textin;
  logic [BLOCK_W-1:0] r_out_data;
  logic               r_out_valid;
  logic               r_core_start;
  logic               r_in_ready;

  logic [BLOCK_W-1:0] r_fifo [FIFO_DEPTH];
  ptr_t               r_wptr;
  ptr_t               r_rptr;
  cnt_t               r_count;

  logic               w_busy;
  logic               w_push;
  logic               w_pop;
  logic               w_iv_load;
  cnt_t               w_count_next;
  logic [BLOCK_W-1:0] w_head;
  logic [BLOCK_W-1:0] w_textin;
  logic [BLOCK_W-1:0] w_result;
  logic [BLOCK_W-1:0] w_chain_next;

  assign w_busy    = (r_count != '0) || (r_state != S_IDLE);
  assign w_push    = IN_VALID && r_in_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_iv_load = IV_LOAD && !w_busy;
  assign w_head    = r_fifo[r_rptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + cnt_t'(1);
      2'b01:   w_count_next = r_count - cnt_t'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Core operand chosen at pop time; chain cannot change until DONE because
  // IV_LOAD is refused while busy.
  always_comb begin
    w_textin = w_head;
    case (r_mode)
      M_CBC:   if (!r_core_encdec) w_textin = w_head ^ r_chain;
      M_CTR:   w_textin = r_chain;
      default: w_textin = w_head;
    endcase
  end

  always_comb begin
    w_result     = CORE_TEXTOUT;
    w_chain_next = r_chain;
    case (r_mode)
      M_CBC: begin
        if (r_core_encdec) begin
          w_result     = CORE_TEXTOUT ^ r_chain;
          w_chain_next = r_block;
        end else begin
          w_chain_next = CORE_TEXTOUT;
        end
      end
      M_CTR: begin
        w_result                  = r_block ^ CORE_TEXTOUT;
        w_chain_next[CTR_W-1:0]   = r_chain[CTR_W-1:0] + CTR_W'(1);
      end
      default: begin
        w_result     = CORE_TEXTOUT;
        w_chain_next = r_chain;
      end
    endcase
  end

  // FIFO storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= IN_DATA;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= S_IDLE;
      r_mode        <= M_ECB;
      r_core_encdec <= 1'b0;
      r_key         <= '0;
      r_chain       <= '0;
      r_block       <= '0;
      r_textin      <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_core_start  <= 1'b0;
      r_in_ready    <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != DEPTH_C);
      if (w_push) r_wptr <= r_wptr + ptr_t'(1);

      if (w_iv_load) begin
        r_mode        <= mode_t'(MODE);
        r_core_encdec <= (MODE == 2'd2) ? 1'b0 : ENCDEC;
        r_key         <= KEY;
        r_chain       <= IV;
      end

      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_rptr       <= r_rptr + ptr_t'(1);
            r_block      <= w_head;
            r_textin     <= w_textin;
            r_core_start <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (CORE_DONE) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
            r_chain     <= w_chain_next;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AES_MODE_BLKCNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_blk_cnt <= '0;
    end else if (w_iv_load) begin
      r_blk_cnt <= '0;
    end else if ((r_state == S_OUT) && OUT_READY && (r_blk_cnt != '1)) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign BLK_CNT = r_blk_cnt;
`else
  assign BLK_CNT = '0;
`endif

  assign BUSY        = w_busy;
  assign IN_READY    = r_in_ready;
  assign OUT_VALID   = r_out_valid;
  assign OUT_DATA    = r_out_data;
  assign CORE_START  = r_core_start;
  assign CORE_ENCDEC = r_core_encdec;
  assign CORE_KEY    = r_key;
  assign CORE_TEXTIN = r_textin;

endmodule
